// File: rtl/memory_access.sv
// memory_access: MEM stage of a five-stage pipeline with a little-endian,
// byte-addressed data memory of 32-bit words. It registers the MEM/WB slot
// and supplies a combinational write-back/forwarding value.
// Optional feature: define MEMORY_ACCESS_DEBUG_PORT_EN to add a
// registered word-read debug port (i_debug_addr / o_debug_data).
module memory_access #(
    parameter int PROC_BITS      = 32,
    parameter int PC_BITS        = 32,
    parameter int REG_ADDRS_BITS = 5,
    parameter int MEM_ADDR_BITS  = 10
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_enable,
    input  logic [PROC_BITS-1:0]      i_alu_result,
    input  logic [PROC_BITS-1:0]      i_rt_data,
    input  logic [REG_ADDRS_BITS-1:0] i_rd,
    input  logic                      i_RegWrite,
    input  logic                      i_MemRead,
    input  logic                      i_MemWrite,
    input  logic                      i_MemtoReg,
    input  logic                      i_pc_to_reg,
    input  logic [2:0]                i_ls_filter_op,
    input  logic [PC_BITS-1:0]        i_pc_return,
    output logic [PROC_BITS-1:0]      o_read_data,
    output logic [PROC_BITS-1:0]      o_alu_result,
    output logic [REG_ADDRS_BITS-1:0] o_rd,
    output logic                      o_RegWrite,
    output logic                      o_MemtoReg,
    output logic                      o_pc_to_reg,
    output logic                      o_misaligned,
    output logic [PC_BITS-1:0]        o_pc_return,
`ifdef MEMORY_ACCESS_DEBUG_PORT_EN
    input  logic [MEM_ADDR_BITS-1:0]  i_debug_addr,
    output logic [PROC_BITS-1:0]      o_debug_data,
`endif
    output logic [PROC_BITS-1:0]      o_wb_data
);

    localparam int DEPTH = 1 << MEM_ADDR_BITS;

    // Address decode: word index and byte offset; higher address bits are ignored.
    logic [MEM_ADDR_BITS-1:0] word_idx;
    logic [1:0]               byte_off;
    logic [1:0]               acc_size;
    logic                     load_unsigned;
    logic                     unused_addr_bits;

    assign word_idx         = i_alu_result[MEM_ADDR_BITS+1:2];
    assign byte_off         = i_alu_result[1:0];
    assign acc_size         = i_ls_filter_op[1:0];
    assign load_unsigned    = i_ls_filter_op[2];
    assign unused_addr_bits = ^i_alu_result[PROC_BITS-1:MEM_ADDR_BITS+2];

    logic        misaligned;
    logic [3:0]  byte_en;
    logic [31:0] store_word;
    logic        mem_wr_en;
    logic [31:0] rd_word;

    // Alignment check and store lane selection; store data is replicated
    // across lanes so each enabled lane already sees its own bytes.
    always_comb begin
        misaligned = 1'b0;
        byte_en    = 4'b0000;
        store_word = i_rt_data[31:0];
        case (acc_size)
            2'b00: begin
                byte_en    = 4'b0001 << byte_off;
                store_word = {4{i_rt_data[7:0]}};
            end
            2'b01: begin
                misaligned = byte_off[0];
                byte_en    = byte_off[1] ? 4'b1100 : 4'b0011;
                store_word = {2{i_rt_data[15:0]}};
            end
            default: begin
                misaligned = (byte_off != 2'b00);
                byte_en    = 4'b1111;
                store_word = i_rt_data[31:0];
            end
        endcase
    end

    // Reset and stall both block writes; misaligned stores are dropped.
    assign mem_wr_en = i_enable & ~i_reset & i_MemWrite & ~misaligned;

`ifdef MEMORY_ACCESS_DEBUG_PORT_EN
    logic [31:0] dbg_word;
`endif

    // One byte-wide RAM per lane so byte enables map onto separate arrays.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];

            // Lane write on its byte enable; contents survive reset.
            always_ff @(posedge i_clock) begin
                if (mem_wr_en && byte_en[gi]) begin
                    lane_mem[word_idx] <= store_word[gi*8 +: 8];
                end
            end

            assign rd_word[gi*8 +: 8] = lane_mem[word_idx];

`ifdef MEMORY_ACCESS_DEBUG_PORT_EN
            logic [7:0] dbg_byte_q;

            // Debug read runs every cycle, independent of the pipeline stall.
            always_ff @(posedge i_clock) begin
                if (i_reset) begin
                    dbg_byte_q <= 8'h00;
                end else begin
                    dbg_byte_q <= lane_mem[i_debug_addr];
                end
            end

            assign dbg_word[gi*8 +: 8] = dbg_byte_q;
`endif
        end
    endgenerate

`ifdef MEMORY_ACCESS_DEBUG_PORT_EN
    assign o_debug_data = PROC_BITS'(dbg_word);
`endif

    logic [7:0]           sel_byte;
    logic [15:0]          sel_half;
    logic [PROC_BITS-1:0] load_val;

    // Load lane extraction followed by sign or zero extension.
    always_comb begin
        sel_byte = rd_word[{byte_off, 3'b000} +: 8];
        sel_half = byte_off[1] ? rd_word[31:16] : rd_word[15:0];
        load_val = PROC_BITS'(rd_word);
        case (acc_size)
            2'b00: load_val = load_unsigned ? PROC_BITS'(sel_byte)
                                            : {{(PROC_BITS-8){sel_byte[7]}}, sel_byte};
            2'b01: load_val = load_unsigned ? PROC_BITS'(sel_half)
                                            : {{(PROC_BITS-16){sel_half[15]}}, sel_half};
            default: load_val = PROC_BITS'(rd_word);
        endcase
    end

    logic [PROC_BITS-1:0]      read_data_q,  read_data_d;
    logic [PROC_BITS-1:0]      alu_result_q, alu_result_d;
    logic [REG_ADDRS_BITS-1:0] rd_q,         rd_d;
    logic                      reg_write_q,  reg_write_d;
    logic                      mem_to_reg_q, mem_to_reg_d;
    logic                      pc_to_reg_q,  pc_to_reg_d;
    logic                      misaligned_q, misaligned_d;
    logic [PC_BITS-1:0]        pc_return_q,  pc_return_d;

    // Next MEM/WB slot; a simultaneous read+write behaves as a store only.
    always_comb begin
        read_data_d  = '0;
        if (i_MemRead && !i_MemWrite && !misaligned) begin
            read_data_d = load_val;
        end
        misaligned_d = (i_MemRead | i_MemWrite) & misaligned;
        alu_result_d = i_alu_result;
        rd_d         = i_rd;
        reg_write_d  = i_RegWrite;
        mem_to_reg_d = i_MemtoReg;
        pc_to_reg_d  = i_pc_to_reg;
        pc_return_d  = i_pc_return;
    end

    // MEM/WB pipeline register: reset clears, stall holds.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            read_data_q  <= '0;
            alu_result_q <= '0;
            rd_q         <= '0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            pc_to_reg_q  <= 1'b0;
            misaligned_q <= 1'b0;
            pc_return_q  <= '0;
        end else if (i_enable) begin
            read_data_q  <= read_data_d;
            alu_result_q <= alu_result_d;
            rd_q         <= rd_d;
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            pc_to_reg_q  <= pc_to_reg_d;
            misaligned_q <= misaligned_d;
            pc_return_q  <= pc_return_d;
        end
    end

    assign o_read_data  = read_data_q;
    assign o_alu_result = alu_result_q;
    assign o_rd         = rd_q;
    assign o_RegWrite   = reg_write_q;
    assign o_MemtoReg   = mem_to_reg_q;
    assign o_pc_to_reg  = pc_to_reg_q;
    assign o_misaligned = misaligned_q;
    assign o_pc_return  = pc_return_q;

    // Write-back / forwarding mux: link address, then load data, then ALU result.
    always_comb begin
        o_wb_data = alu_result_q;
        if (pc_to_reg_q) begin
            o_wb_data = PROC_BITS'(pc_return_q);
        end else if (mem_to_reg_q) begin
            o_wb_data = read_data_q;
        end
    end

endmodule

// File: tb/tb_memory_access.sv
// Self-checking bench for memory_access: directed scenarios with literal
// expectations plus randomized traffic against a byte-array reference model.
module tb_memory_access;

    logic        clk = 1'b0;
    logic        rst, en, regw, memr, memw, m2r, p2r;
    logic [31:0] alu, rt, pc;
    logic [4:0]  rd;
    logic [2:0]  op;

    logic [31:0] read_data, alu_o, pc_o, wb;
    logic [4:0]  rd_o;
    logic        regw_o, m2r_o, p2r_o, mis_o;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Reference model state: byte-addressed memory and expected MEM/WB slot.
    logic [7:0]  mm [0:4095];
    logic [31:0] e_read, e_alu, e_pc;
    logic [4:0]  e_rd;
    logic        e_regw, e_m2r, e_p2r, e_mis;

    always #5 clk = ~clk;

    memory_access #(
        .PROC_BITS(32), .PC_BITS(32), .REG_ADDRS_BITS(5), .MEM_ADDR_BITS(10)
    ) dut (
        .i_clock(clk), .i_reset(rst), .i_enable(en),
        .i_alu_result(alu), .i_rt_data(rt), .i_rd(rd),
        .i_RegWrite(regw), .i_MemRead(memr), .i_MemWrite(memw),
        .i_MemtoReg(m2r), .i_pc_to_reg(p2r), .i_ls_filter_op(op),
        .i_pc_return(pc),
        .o_read_data(read_data), .o_alu_result(alu_o), .o_rd(rd_o),
        .o_RegWrite(regw_o), .o_MemtoReg(m2r_o), .o_pc_to_reg(p2r_o),
        .o_misaligned(mis_o), .o_pc_return(pc_o), .o_wb_data(wb)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_wb();
        if (e_p2r) return e_pc;
        if (e_m2r) return e_read;
        return e_alu;
    endfunction

    // Reference model: evaluated at each rising edge from the applied inputs.
    task automatic model_step();
        int          a, n;
        logic [31:0] v;
        bit          mis;
        if (rst) begin
            e_read = 0; e_alu = 0; e_pc = 0; e_rd = 0;
            e_regw = 0; e_m2r = 0; e_p2r = 0; e_mis = 0;
        end else if (en) begin
            a   = int'(alu & 32'h0000_0FFF);
            n   = (op[1:0] == 2'b00) ? 1 : (op[1:0] == 2'b01) ? 2 : 4;
            mis = (a % n) != 0;
            e_mis  = (memr || memw) && mis;
            e_read = 0;
            if (memw) begin
                if (!mis) for (int k = 0; k < n; k++) mm[a + k] = 8'(rt >> (8 * k));
            end else if (memr && !mis) begin
                v = 0;
                for (int k = 0; k < n; k++) v = v | (32'(mm[a + k]) << (8 * k));
                if (n < 4 && !op[2] && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
                e_read = v;
            end
            e_alu = alu; e_rd = rd; e_regw = regw; e_m2r = m2r; e_p2r = p2r; e_pc = pc;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input bit r, input bit e, input bit mr, input bit mw,
                         input bit m2, input bit p2, input logic [2:0] o,
                         input logic [31:0] a, input logic [31:0] d, input logic [31:0] p);
        rst = r; en = e; memr = mr; memw = mw; m2r = m2; p2r = p2;
        op = o; alu = a; rt = d; pc = p; rd = 5'd3; regw = 1'b1;
    endtask

    // Compare process: every registered output and the write-back value, every cycle.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("read_data",  read_data, e_read);
            check("alu_result", alu_o,     e_alu);
            check("rd",         32'(rd_o), 32'(e_rd));
            check("RegWrite",   32'(regw_o), 32'(e_regw));
            check("MemtoReg",   32'(m2r_o),  32'(e_m2r));
            check("pc_to_reg",  32'(p2r_o),  32'(e_p2r));
            check("misaligned", 32'(mis_o),  32'(e_mis));
            check("pc_return",  pc_o,      e_pc);
            check("wb_data",    wb,        exp_wb());
        end
    end

    initial begin
        drive(1, 0, 0, 0, 0, 0, 3'b010, 0, 0, 0);
        tick();
        cmp_en = 1'b1;
        check("reset_read", read_data, 32'h0);
        check("reset_wb", wb, 32'h0);
        tick();
        drive(0, 1, 0, 0, 0, 0, 3'b010, 0, 0, 0);
        tick();

        // Fill memory so every later load has a known reference.
        for (int w = 0; w < 1024; w++) begin
            drive(0, 1, 0, 1, 0, 0, 3'b010, 32'(w * 4), $urandom, 0);
            tick();
        end

        // Word store then word load.
        drive(0, 1, 0, 1, 0, 0, 3'b010, 32'h10, 32'h1122_3344, 0); tick();
        drive(0, 1, 1, 0, 1, 0, 3'b010, 32'h10, 0, 0); tick();
        check("sw_lw_read", read_data, 32'h1122_3344);
        check("sw_lw_wb", wb, 32'h1122_3344);

        // Byte store, signed/unsigned byte loads, neighbour bytes intact.
        drive(0, 1, 0, 1, 0, 0, 3'b010, 32'h20, 32'hAABB_CCDD, 0); tick();
        drive(0, 1, 0, 1, 0, 0, 3'b000, 32'h21, 32'h0000_0080, 0); tick();
        drive(0, 1, 1, 0, 1, 0, 3'b000, 32'h21, 0, 0); tick();
        check("lb_signed", read_data, 32'hFFFF_FF80);
        drive(0, 1, 1, 0, 1, 0, 3'b100, 32'h21, 0, 0); tick();
        check("lbu", read_data, 32'h0000_0080);
        drive(0, 1, 1, 0, 1, 0, 3'b010, 32'h20, 0, 0); tick();
        check("sb_neighbours", read_data, 32'hAABB_80DD);

        // Misaligned half store is dropped and flagged.
        drive(0, 1, 0, 1, 0, 0, 3'b001, 32'h13, 32'h0000_FFFF, 0); tick();
        check("sh_misaligned_flag", 32'(mis_o), 32'h1);
        drive(0, 1, 1, 0, 1, 0, 3'b010, 32'h10, 0, 0); tick();
        check("after_misaligned", read_data, 32'h1122_3344);
        check("misaligned_clear", 32'(mis_o), 32'h0);

        // Stalled store never lands.
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 1, 0, 0, 3'b010, 32'h10, 32'hDEAD_BEEF, 0); tick();
            check("stall_hold", read_data, 32'h1122_3344);
        end
        drive(0, 1, 1, 0, 1, 0, 3'b010, 32'h10, 0, 0); tick();
        check("stall_no_write", read_data, 32'h1122_3344);

        // Stalled store lands on the first enabled cycle; next-cycle read sees it.
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 1, 0, 0, 3'b010, 32'h10, 32'hDEAD_BEEF, 0); tick();
        end
        drive(0, 1, 0, 1, 0, 0, 3'b010, 32'h10, 32'hDEAD_BEEF, 0); tick();
        drive(0, 1, 1, 0, 1, 0, 3'b010, 32'h10, 0, 0); tick();
        check("write_after_stall", read_data, 32'hDEAD_BEEF);

        // Store coinciding with reset is lost; outputs clear.
        drive(1, 1, 0, 1, 0, 0, 3'b010, 32'h10, 32'h5555_5555, 32'h44); tick();
        check("reset_sw_read", read_data, 32'h0);
        check("reset_sw_alu", alu_o, 32'h0);
        check("reset_sw_wb", wb, 32'h0);
        drive(0, 1, 1, 0, 1, 0, 3'b010, 32'h10, 0, 0); tick();
        check("reset_sw_mem", read_data, 32'hDEAD_BEEF);

        // Link address wins the write-back mux.
        drive(0, 1, 1, 0, 1, 1, 3'b010, 32'h10, 0, 32'h40); tick();
        check("pc_to_reg_m2r", wb, 32'h40);
        drive(0, 1, 0, 0, 0, 1, 3'b010, 32'h1234, 0, 32'h40); tick();
        check("pc_to_reg_alu", wb, 32'h40);

        // Randomized traffic over a small window with random upper address bits.
        for (int i = 0; i < 2000; i++) begin
            rst  = ($urandom_range(0, 99) == 0);
            en   = ($urandom_range(0, 4) != 0);
            memr = 1'($urandom_range(0, 1));
            memw = ($urandom_range(0, 2) == 0);
            m2r  = 1'($urandom_range(0, 1));
            p2r  = ($urandom_range(0, 3) == 0);
            regw = 1'($urandom_range(0, 1));
            op   = 3'($urandom_range(0, 7));
            alu  = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
            rt   = $urandom;
            pc   = $urandom;
            rd   = 5'($urandom_range(0, 31));
            tick();
        end

        drive(0, 0, 0, 0, 0, 0, 3'b010, 0, 0, 0);
        tick();
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_access.md
MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 Parameter PROC_BITS, default 32, data path width.
REQ-002 Parameter PC_BITS, default 32, return-address width.
REQ-003 Parameter REG_ADDRS_BITS, default 5, register-address width.
REQ-004 Parameter MEM_ADDR_BITS, default 10, word-index width; memory depth is 2**MEM_ADDR_BITS words.
REQ-005 Ports SHALL be, clock and reset first:
- i_clock  in  1  single clock; all state updates on its rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_enable  in  1  pipeline advance; low = stall.
- i_alu_result  in  PROC_BITS  byte address for loads/stores, or ALU result to pass through.
- i_rt_data  in  PROC_BITS  store data.
- i_rd  in  REG_ADDRS_BITS  destination register.
- i_RegWrite, i_MemRead, i_MemWrite, i_MemtoReg, i_pc_to_reg  in  1 each  control from execution.
- i_ls_filter_op  in  3  [1:0] size (00 byte, 01 half, 10 word, 11 reserved = word); [2] unsigned load.
- i_pc_return  in  PC_BITS  link address.
- o_read_data, o_alu_result  out  PROC_BITS  registered MEM/WB data.
- o_rd  out  REG_ADDRS_BITS  registered destination register.
- o_RegWrite, o_MemtoReg, o_pc_to_reg, o_misaligned  out  1 each  registered flags.
- o_pc_return  out  PC_BITS  registered link address.
- o_wb_data  out  PROC_BITS  combinational write-back/forwarding value.

Function
REQ-006 Memory SHALL be little-endian, byte-addressed; word index = i_alu_result[MEM_ADDR_BITS+1:2], offset = i_alu_result[1:0]; upper address bits are ignored.
REQ-007 Misaligned SHALL mean half with offset[0]=1, or word with offset!=0; a byte access is never misaligned.
REQ-008 When i_enable=1, i_MemWrite=1 and the access is aligned, the store SHALL write, at the clock edge, only the addressed lanes: byte = lane offset; half = lanes {offset[1],0} and {offset[1],1}; word = all four lanes.
REQ-009 Store data SHALL come from the low bits of i_rt_data, shifted to the addressed lane(s).
REQ-010 A load (i_MemRead=1, aligned) SHALL extract the addressed byte or half, then sign-extend it (bit2=0) or zero-extend it (bit2=1); a word load SHALL return the full word.
REQ-011 The result of REQ-010 SHALL be registered into o_read_data at the same edge: latency is exactly 1 cycle, input to output.
REQ-012 If i_MemRead=0 or the access is misaligned, o_read_data SHALL load 0.
REQ-013 Misaligned accesses SHALL be suppressed (no write) and SHALL set o_misaligned=1 for that registered slot; otherwise o_misaligned=0.
REQ-014 i_MemRead and i_MemWrite both high SHALL be treated as a store only, with o_read_data=0.
REQ-015 When i_enable=1, o_alu_result, o_rd, o_RegWrite, o_MemtoReg, o_pc_to_reg and o_pc_return SHALL register their inputs.
REQ-016 When i_enable=0, all registered outputs SHALL hold, and no memory write SHALL occur.
REQ-017 o_wb_data SHALL be: o_pc_return (zero-extended) if o_pc_to_reg; else o_read_data if o_MemtoReg; else o_alu_result.
REQ-018 A write followed by a read of the same word on the next enabled cycle SHALL return the newly written data.

Reset
REQ-019 While i_reset=1, every registered output SHALL be 0 on the next edge, and o_wb_data SHALL therefore be 0.
REQ-020 While i_reset=1, memory writes SHALL be blocked; reset has priority over i_enable.
REQ-021 Memory contents SHALL NOT be cleared by reset; a store coinciding with reset is lost.

Configuration
REQ-022 Macro MEMORY_ACCESS_DEBUG_PORT_EN defined: extra ports i_debug_addr (in, MEM_ADDR_BITS, word index) and o_debug_data (out, PROC_BITS) SHALL exist; o_debug_data = word at i_debug_addr, registered 1 cycle, independent of i_enable, reset to 0.
REQ-023 Macro undefined: these ports and their logic SHALL be absent; all other behaviour is unchanged.

Verification
REQ-024 SW 0x11223344 to addr 0x10, then LW 0x10 -> o_read_data=0x11223344, o_wb_data equals it with MemtoReg=1.
REQ-025 SB 0x80 to addr 0x21, then LB 0x21 -> 0xFFFFFF80; LBU 0x21 -> 0x00000080; other bytes of word 8 unchanged.
REQ-026 SH to addr 0x13 -> no write, o_misaligned=1; following LW 0x10 returns the prior value.
REQ-027 i_enable=0 for 3 cycles with MemWrite=1 -> outputs hold, memory unchanged; write occurs on the first enabled cycle.
REQ-028 i_reset asserted during a SW -> all outputs 0 next cycle, memory unchanged.
REQ-029 pc_to_reg=1, pc_return=0x40 -> o_wb_data=0x40 regardless of MemtoReg.
